// File: rtl/alu_seq_pkg.sv
// Shared types and decode helpers for the alu_seq execute-stage controller.
// Defining ALU_SEQ_WORD_EN adds the RV64M word ops (MULW/DIVW/DIVUW/REMW/REMUW).
package alu_seq_pkg;

  localparam int XLEN = 64;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_SLL  = 5'd2,
    OP_SLT  = 5'd3,
    OP_SLTU = 5'd4,
    OP_XOR  = 5'd5,
    OP_SRL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_OR   = 5'd8,
    OP_AND  = 5'd9,
    OP_MUL  = 5'd10,
    OP_DIV  = 5'd11,
    OP_DIVU = 5'd12,
    OP_REM  = 5'd13,
    OP_REMU = 5'd14
`ifdef ALU_SEQ_WORD_EN
    ,
    OP_MULW  = 5'd15,
    OP_DIVW  = 5'd16,
    OP_DIVUW = 5'd17,
    OP_REMW  = 5'd18,
    OP_REMUW = 5'd19
`endif
  } op_t;

  typedef enum logic [1:0] {
    SRC_RS2  = 2'd0,
    SRC_IMM  = 2'd1,
    SRC_FOUR = 2'd3
  } src_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ALU  = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Codes outside op_t fall through to the default and are ALU-class.
  function automatic logic is_mop(input logic [4:0] op);
    case (op)
      OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
`ifdef ALU_SEQ_WORD_EN
      OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    case (op)
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
`ifdef ALU_SEQ_WORD_EN
      OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_sgn(input logic [4:0] op);
    case (op)
      OP_DIV, OP_REM: return 1'b1;
`ifdef ALU_SEQ_WORD_EN
      OP_DIVW, OP_REMW: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_rem(input logic [4:0] op);
    case (op)
      OP_REM, OP_REMU: return 1'b1;
`ifdef ALU_SEQ_WORD_EN
      OP_REMW, OP_REMUW: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_word(input logic [4:0] op);
    case (op)
`ifdef ALU_SEQ_WORD_EN
      OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider with sign fix-up.
// Word ops (ALU_SEQ_WORD_EN) run 32 steps on 32-bit extended operands.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int ITERS = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic            step,
  input  logic            fix,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            special,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LIM_D = CW'(ITERS - 1);
  localparam logic [CW-1:0] LIM_W = CW'(31);

  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input logic w,
                                          input logic sg);
    if (!w) return v;
    return sg ? {{(XLEN-32){v[31]}}, v[31:0]} : {{(XLEN-32){1'b0}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  logic            w_i, sg_i, dv_i, div0_i, ovf_i;
  logic [XLEN-1:0] xa, xb, ma, mb, min_v;

  always_comb begin
    w_i    = is_word(op);
    sg_i   = is_sgn(op);
    dv_i   = is_div(op);
    xa     = ext(a, w_i, sg_i);
    xb     = ext(b, w_i, sg_i);
    ma     = (sg_i & xa[XLEN-1]) ? -xa : xa;
    mb     = (sg_i & xb[XLEN-1]) ? -xb : xb;
    min_v  = w_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div0_i = dv_i && (xb == '0);
    ovf_i  = dv_i && sg_i && (xa == min_v) && (xb == '1);
    special = div0_i | ovf_i;
  end

  // opa: multiplicand / divisor; opb: multiplier / dividend-then-quotient; acc: product / remainder
  logic [XLEN-1:0] opa, opb, acc, r_a;
  logic            r_w, r_div, r_rem, r_negq, r_negr, r_div0, r_ovf;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] diff;

  always_comb begin
    trial = {acc, opb[XLEN-1]};
    ge    = trial >= {1'b0, opa};
    diff  = trial[XLEN-1:0] - opa;
    last  = (cnt == (r_w ? LIM_W : LIM_D));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opa <= '0; opb <= '0; acc <= '0; r_a <= '0; cnt <= '0;
      r_w <= 1'b0; r_div <= 1'b0; r_rem <= 1'b0; r_negq <= 1'b0;
      r_negr <= 1'b0; r_div0 <= 1'b0; r_ovf <= 1'b0;
    end else if (flush || fix) begin
      cnt <= '0;
    end else if (start) begin
      r_w    <= w_i;
      r_div  <= dv_i;
      r_rem  <= is_rem(op);
      r_negq <= sg_i & (xa[XLEN-1] ^ xb[XLEN-1]);
      r_negr <= sg_i & xa[XLEN-1];
      r_div0 <= div0_i;
      r_ovf  <= ovf_i;
      r_a    <= xa;
      acc    <= '0;
      cnt    <= '0;
      if (dv_i) begin
        opa <= mb;
        // Word dividends sit in the top half so 32 steps consume exactly them.
        opb <= w_i ? {ma[31:0], {(XLEN-32){1'b0}}} : ma;
      end else begin
        opa <= xa;
        opb <= xb;
      end
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (r_div) begin
        acc <= ge ? diff : trial[XLEN-1:0];
        opb <= {opb[XLEN-2:0], ge};
      end else begin
        if (opb[0]) acc <= acc + opa;
        opa <= opa << 1;
        opb <= opb >> 1;
      end
    end
  end

  logic [XLEN-1:0] res;

  always_comb begin
    res = acc;
    if (r_div) begin
      if (r_div0)     res = r_rem ? r_a : '1;
      else if (r_ovf) res = r_rem ? '0 : r_a;
      else if (r_rem) res = apply_sign(acc, r_negr);
      else            res = apply_sign(opb, r_negq);
    end
    result = r_w ? {{(XLEN-32){res[31]}}, res[31:0]} : res;
  end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage controller: single-cycle ALU ops via the shared ALU, M ops via alu_seq_iter.
// Build with ALU_SEQ_WORD_EN to enable the RV64M word ops.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int ITERS = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [1:0]      in_src,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] alu_result,
  output logic [1:0]      alub_sel,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data
);

  state_t          state, state_nx;
  logic [1:0]      src_q;
  logic            accept, special, last, start, step, fix;
  logic [XLEN-1:0] iter_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready & ~flush;

  alu_seq_iter #(.XLEN(XLEN), .ITERS(ITERS)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .start   (start),
    .step    (step),
    .fix     (fix),
    .op      (in_op),
    .a       (rs1_val),
    .b       (rs2_val),
    .special (special),
    .last    (last),
    .result  (iter_res)
  );

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    step     = 1'b0;
    fix      = 1'b0;
    alub_sel = 2'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mop(in_op)) begin
            start    = 1'b1;
            state_nx = special ? FIX : ITER;
          end else begin
            state_nx = ALU;
          end
        end
      end
      ALU: begin
        alub_sel = (src_q == 2'd2) ? 2'd0 : src_q;
        state_nx = DONE;
      end
      ITER: begin
        step = 1'b1;
        if (last) state_nx = FIX;
      end
      FIX: begin
        fix      = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
      step     = 1'b0;
      fix      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      src_q    <= 2'd0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      if (accept) src_q <= in_src;
      if (!flush && state == ALU) out_data <= alu_result;
      if (fix) out_data <= iter_res;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: cycle-level behavioural model plus literal expectations.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic        in_ready, out_valid;
  logic [4:0]  in_op;
  logic [1:0]  in_src, alub_sel;
  logic [63:0] rs1_val, rs2_val, alu_result, out_data;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  alu_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src(in_src), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .alu_result(alu_result), .alub_sel(alub_sel), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic ok, input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic tb_is_m(input logic [4:0] op);
    return op inside {OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic tb_special(input logic [4:0] op, input logic [63:0] a,
                                      input logic [63:0] b);
    if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU} && b == 64'd0) return 1'b1;
    if (op inside {OP_DIV, OP_REM} && a == MIN && b == ONES) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] mres(input logic [4:0] op, input logic [63:0] a,
                                       input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == MIN) && (b == ONES);
    case (op)
      OP_MUL: return a * b;
      OP_DIV: begin
        if (b == 64'd0) return ONES;
        if (ovf) return MIN;
        return sa / sb;
      end
      OP_DIVU: begin
        if (b == 64'd0) return ONES;
        return a / b;
      end
      OP_REM: begin
        if (b == 64'd0) return a;
        if (ovf) return 64'd0;
        return sa % sb;
      end
      OP_REMU: begin
        if (b == 64'd0) return a;
        return a % b;
      end
      default: return 64'd0;
    endcase
  endfunction

  // Transaction-level model: busy flag, edges remaining until the result shows, expected result.
  logic        started = 1'b0;
  logic        m_busy = 1'b0, m_valid = 1'b0, m_alu = 1'b0, m_fresh = 1'b1;
  logic [1:0]  m_sel = 2'd0;
  logic [63:0] m_data = 64'd0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      started <= 1'b1;
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_alu   <= 1'b0;
      m_fresh <= 1'b1;
    end else if (flush) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_alu   <= 1'b0;
    end else if (!m_busy) begin
      m_alu <= 1'b0;
      if (in_valid) begin
        m_busy  <= 1'b1;
        m_fresh <= 1'b0;
        if (tb_is_m(in_op)) begin
          m_data <= mres(in_op, rs1_val, rs2_val);
          m_left <= tb_special(in_op, rs1_val, rs2_val) ? 1 : 65;
        end else begin
          m_data <= alu_result;
          m_left <= 1;
          m_alu  <= 1'b1;
          m_sel  <= (in_src == 2'd2) ? 2'd0 : in_src;
        end
      end
    end else begin
      m_alu <= 1'b0;
      if (m_valid) begin
        if (out_ready) begin
          m_valid <= 1'b0;
          m_busy  <= 1'b0;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) m_valid <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      chk(in_ready == !m_busy, "mon_in_ready", {63'd0, in_ready}, {63'd0, !m_busy});
      chk(out_valid == m_valid, "mon_out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      chk(alub_sel == (m_alu ? m_sel : 2'd0), "mon_alub_sel", {62'd0, alub_sel},
          {62'd0, (m_alu ? m_sel : 2'd0)});
      if (m_valid) chk(out_data == m_data, "mon_out_data", out_data, m_data);
      if (m_fresh) chk(out_data == 64'd0, "mon_out_data_reset", out_data, 64'd0);
    end
  end

  task automatic wait_valid(input string nm, output int n);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk(1'b0, {nm, "_timeout"}, n, 200);
  endtask

  task automatic release_out(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk(in_ready && !out_valid, {nm, "_ret"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic do_op(input string nm, input logic [4:0] op, input logic [1:0] src,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] r,
                       input logic [63:0] exp, input int exp_lat, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1; in_op = op; in_src = src;
    rs1_val = a; rs2_val = b; alu_result = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!tb_is_m(op))
      chk(alub_sel == ((src == 2'd2) ? 2'd0 : src), {nm, "_sel"}, {62'd0, alub_sel},
          {62'd0, src});
    wait_valid(nm, n);
    chk(n == exp_lat, {nm, "_lat"}, n, exp_lat);
    chk(out_data == exp, {nm, "_data"}, out_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk(out_valid && !in_ready && out_data == exp, {nm, "_hold"}, out_data, exp);
    end
    release_out(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_op = 5'd0; in_src = 2'd0; rs1_val = '0; rs2_val = '0; alu_result = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk(in_ready && !out_valid && out_data == 64'd0 && alub_sel == 2'd0, "reset_state",
        out_data, 64'd0);

    do_op("add_imm", OP_ADD, 2'd1, 64'd3, 64'd4, 64'h10, 64'h10, 2, 0);
    do_op("sub_rsv", OP_SUB, 2'd2, 64'd1, 64'd2, 64'hDEAD, 64'hDEAD, 2, 0);
    do_op("slt_four", OP_SLT, 2'd3, 64'd1, 64'd2, 64'h4, 64'h4, 2, 0);
    do_op("undef_op", 5'd31, 2'd0, 64'd1, 64'd2, 64'h1234_5678_9ABC_DEF0,
          64'h1234_5678_9ABC_DEF0, 2, 0);
    do_op("div_100_7", OP_DIV, 2'd0, 64'd100, 64'd7, 64'hBAD, 64'd14, 66, 5);
    do_op("rem_100_7", OP_REM, 2'd0, 64'd100, 64'd7, 64'hBAD, 64'd2, 66, 0);
    do_op("rem_m7_2", OP_REM, 2'd0, -64'd7, 64'd2, 64'hBAD, ONES, 66, 0);
    do_op("div_m7_2", OP_DIV, 2'd0, -64'd7, 64'd2, 64'hBAD, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
    do_op("rem_7_m2", OP_REM, 2'd0, 64'd7, -64'd2, 64'hBAD, 64'd1, 66, 0);
    do_op("divu_big", OP_DIVU, 2'd0, ONES, 64'd10, 64'hBAD, 64'h1999_9999_9999_9999, 66, 0);
    do_op("remu_big", OP_REMU, 2'd0, ONES, 64'd10, 64'hBAD, 64'd5, 66, 0);
    do_op("mul_big", OP_MUL, 2'd0, 64'd123456789, 64'd987654321, 64'hBAD,
          64'd121932631112635269, 66, 0);
    do_op("mul_neg", OP_MUL, 2'd0, -64'd3, 64'd5, 64'hBAD, 64'hFFFF_FFFF_FFFF_FFF1, 66, 0);
    do_op("mul_wrap", OP_MUL, 2'd0, 64'h1_0000_0001, 64'h1_0000_0001, 64'hBAD,
          64'h2_0000_0001, 66, 0);
    do_op("divu_z", OP_DIVU, 2'd0, 64'd5, 64'd0, 64'hBAD, ONES, 2, 0);
    do_op("remu_z", OP_REMU, 2'd0, 64'd5, 64'd0, 64'hBAD, 64'd5, 2, 0);
    do_op("div_z", OP_DIV, 2'd0, -64'd5, 64'd0, 64'hBAD, ONES, 2, 0);
    do_op("rem_z", OP_REM, 2'd0, -64'd5, 64'd0, 64'hBAD, 64'hFFFF_FFFF_FFFF_FFFB, 2, 0);
    do_op("div_ovf", OP_DIV, 2'd0, MIN, ONES, 64'hBAD, MIN, 2, 0);
    do_op("rem_ovf", OP_REM, 2'd0, MIN, ONES, 64'hBAD, 64'd0, 2, 0);
    do_op("divu_min", OP_DIVU, 2'd0, MIN, ONES, 64'hBAD, 64'd0, 66, 0);
    do_op("div_min_1", OP_DIV, 2'd0, MIN, 64'd1, 64'hBAD, MIN, 66, 0);
    do_op("rem_min_3", OP_REM, 2'd0, MIN, 64'd3, 64'hBAD, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);

    // Flush at iteration 20 with a competing ADD offered in the same cycle.
    in_valid = 1'b1; in_op = OP_DIV; in_src = 2'd0; rs1_val = 64'd100; rs2_val = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; in_op = OP_ADD; in_src = 2'd1; alu_result = 64'h55;
    @(posedge clk); #1;
    flush = 1'b0;
    chk(in_ready && !out_valid, "flush_idle", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk(!in_ready && alub_sel == 2'd1, "flush_next_accept", {62'd0, alub_sel}, 64'd1);
    wait_valid("flush_add", n);
    chk(n == 2 && out_data == 64'h55, "flush_add_data", out_data, 64'h55);
    release_out("flush_add");

    // No same-cycle accept on the edge that leaves DONE.
    in_valid = 1'b1; in_op = OP_ADD; in_src = 2'd0; alu_result = 64'h77;
    @(posedge clk); #1;
    wait_valid("noacc", n);
    alu_result = 64'h88; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk(in_ready && !out_valid, "noacc_ret", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk(!in_ready, "noacc_reaccept", {63'd0, in_ready}, 64'd0);
    wait_valid("noacc2", n);
    chk(out_data == 64'h88, "noacc2_data", out_data, 64'h88);
    release_out("noacc2");

    // Flush while the result is waiting in DONE.
    in_valid = 1'b1; in_op = OP_XOR; in_src = 2'd0; alu_result = 64'h99;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("done_flush", n);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk(in_ready && !out_valid, "done_flush_idle", {63'd0, out_valid}, 64'd0);

    // Reset in the middle of an iterative op.
    in_valid = 1'b1; in_op = OP_MUL; rs1_val = 64'd9; rs2_val = 64'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk(in_ready && !out_valid && out_data == 64'd0, "midrst_state", out_data, 64'd0);
    repeat (70) begin @(posedge clk); #1; end
    do_op("post_rst", OP_AND, 2'd3, 64'd0, 64'd0, 64'h4, 64'h4, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
